// File: rtl/tile_pkg.sv
// Shared types and screen constants for the falling-tile game sequencer.
package tile_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam int unsigned LANES        = 4;
  localparam int unsigned LANE_W       = 2;
  localparam int unsigned Y_W          = 10;
  localparam int unsigned SUM_W        = 11;
  localparam int unsigned KEY_W        = 8;
  localparam int unsigned SCREEN_Y_MAX = 479;

  // Lane i is selected by LANE_KEY[i].
  localparam logic [LANES-1:0][KEY_W-1:0] LANE_KEY = {8'h09, 8'h07, 8'h16, 8'h04};

endpackage

// File: rtl/tile_scheduler_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used for lane selection.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        Reset_n,
  output logic [15:0] q
);

  logic [15:0] lfsr_d;
  logic [15:0] lfsr_q;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/tile_scheduler.sv
// Game sequencer: spawns tiles into four lanes, scores key hits, ramps speed, detects game over.
module tile_scheduler
  import tile_pkg::*;
#(
  parameter int unsigned SPAWN_FRAMES   = 40,
  parameter int unsigned SPAWN_MIN      = 8,
  parameter int unsigned HIT_TOP        = 300,
  parameter int unsigned Y_MAX          = SCREEN_Y_MAX,
  parameter int unsigned HITS_PER_LEVEL = 8,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                   frame_clk,
  input  logic                   Reset_n,
  input  logic                   start,
  input  logic [KEY_W-1:0]       keycode,
  input  logic [LANES*Y_W-1:0]   lane_y,
  input  logic [Y_W-1:0]         lane_s,
  output logic [LANES-1:0]       new_note,
  output logic [LANES-1:0]       kill,
  output logic [3:0]             speed,
  output logic [15:0]            score,
  output logic                   playing,
  output logic                   game_over
);

  localparam int unsigned TMR_W = $clog2(SPAWN_FRAMES + 1);
  localparam int unsigned LVL_W = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;

  state_t               state_q, state_d;
  logic [LANES-1:0]     new_note_q, new_note_d;
  logic [LANES-1:0]     kill_q, kill_d;
  logic [LANES-1:0]     busy_q, busy_d;
  logic [3:0]           speed_q, speed_d;
  logic [15:0]          score_q, score_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [LVL_W-1:0]     lvl_q, lvl_d;
  logic [KEY_W-1:0]     key_q, key_d;
  logic                 playing_q, playing_d;
  logic                 game_over_q, game_over_d;

  logic [15:0]          lfsr;
  logic                 lfsr_unused_c;
  logic [LANES-1:0][SUM_W-1:0] sum_c;
  logic [LANES-1:0]     hittable_c, bottom_c, press_c;
  logic [LANES-1:0]     hit_c, miss_c, spawn_c;
  logic                 wrong_c, go_over_c, spawn_ok_c;
  logic [LANE_W-1:0]    idx_c;
  logic [4:0]           two_spd_c;
  logic [TMR_W-1:0]     reload_c;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (frame_clk),
    .Reset_n (Reset_n),
    .q       (lfsr)
  );

  assign lfsr_unused_c = ^lfsr[15:LANE_W];

  // Per-lane position classification and key-press decode; sums are 11 bits so they cannot wrap.
  always_comb begin
    sum_c      = '0;
    hittable_c = '0;
    bottom_c   = '0;
    press_c    = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_c[i]      = {1'b0, lane_y[i*Y_W +: Y_W]} + {1'b0, lane_s};
      hittable_c[i] = sum_c[i] >= SUM_W'(HIT_TOP);
      bottom_c[i]   = sum_c[i] >= SUM_W'(Y_MAX);
      press_c[i]    = (keycode != key_q) && (keycode == LANE_KEY[i]);
    end
  end

  // A hit on a lane masks that lane's miss; a miss elsewhere still ends the game.
  always_comb begin
    hit_c     = press_c & busy_q & hittable_c;
    wrong_c   = |(press_c & ~(busy_q & hittable_c));
    miss_c    = busy_q & bottom_c & ~hit_c;
    go_over_c = wrong_c | (|miss_c);
  end

  // First idle lane at or after the random candidate, judged on busy before any hit this cycle.
  always_comb begin
    spawn_c    = '0;
    spawn_ok_c = 1'b0;
    idx_c      = '0;
    for (int k = 0; k < LANES; k++) begin
      idx_c = lfsr[LANE_W-1:0] + LANE_W'(k);
      if (!spawn_ok_c && !busy_q[idx_c]) begin
        spawn_c[idx_c] = 1'b1;
        spawn_ok_c     = 1'b1;
      end
    end
  end

  always_comb begin
    two_spd_c = {speed_q, 1'b0};
    if (32'(two_spd_c) + SPAWN_MIN <= SPAWN_FRAMES) begin
      reload_c = TMR_W'(SPAWN_FRAMES - 32'(two_spd_c));
    end else begin
      reload_c = TMR_W'(SPAWN_MIN);
    end
  end

  always_comb begin
    state_d    = state_q;
    new_note_d = '0;
    kill_d     = '0;
    busy_d     = busy_q;
    speed_d    = speed_q;
    score_d    = score_q;
    timer_d    = timer_q;
    lvl_d      = lvl_q;
    key_d      = keycode;

    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d = RUN;
          kill_d  = '1;
          busy_d  = '0;
          speed_d = '0;
          score_d = '0;
          lvl_d   = '0;
          timer_d = TMR_W'(SPAWN_FRAMES);
        end
      end
      RUN: begin
        if (go_over_c) begin
          state_d = OVER;
          kill_d  = '1;
          busy_d  = '0;
        end else begin
          kill_d = hit_c;
          busy_d = busy_q & ~hit_c;
          if (|hit_c) begin
            if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
            if (lvl_q == LVL_W'(HITS_PER_LEVEL - 1)) begin
              lvl_d = '0;
              if (speed_q != 4'hF) speed_d = speed_q + 4'd1;
            end else begin
              lvl_d = lvl_q + LVL_W'(1);
            end
          end
          // With every lane busy the timer parks at zero and the spawn retries each frame.
          if (timer_q == '0) begin
            if (spawn_ok_c) begin
              new_note_d = spawn_c;
              busy_d     = busy_d | spawn_c;
              timer_d    = reload_c;
            end
          end else begin
            timer_d = timer_q - TMR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    playing_d   = (state_d == RUN);
    game_over_d = (state_d == OVER);
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      new_note_q  <= '0;
      kill_q      <= '0;
      busy_q      <= '0;
      speed_q     <= '0;
      score_q     <= '0;
      timer_q     <= '0;
      lvl_q       <= '0;
      key_q       <= '0;
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      new_note_q  <= new_note_d;
      kill_q      <= kill_d;
      busy_q      <= busy_d;
      speed_q     <= speed_d;
      score_q     <= score_d;
      timer_q     <= timer_d;
      lvl_q       <= lvl_d;
      key_q       <= key_d;
      playing_q   <= playing_d;
      game_over_q <= game_over_d;
    end
  end

  assign new_note  = new_note_q;
  assign kill      = kill_q;
  assign speed     = speed_q;
  assign score     = score_q;
  assign playing   = playing_q;
  assign game_over = game_over_q;

endmodule
